laser_scan_ctrl: RTL and testbench

- Sequencer for the LASER coverage datapath.
- Sweeps every candidate centre of the 16x16 grid, one candidate per cycle, into an external parallel coverage evaluator. That evaluator counts how many of the 40 loaded points lie within r^2<=16 of the candidate centre or of a fixed second centre.
- Alternates optimisation of C1 and C2 (coordinate-descent passes) until a pass brings no improvement or MAX_PASSES is reached, then reports C1/C2 with a one-cycle DONE.
- Sits between the point-loader (which issues START) and the top-level LASER outputs.

---
 rtl/laser_pkg.sv | 35 +++
 rtl/laser_scan_ctrl_best_tracker.sv | 56 +++++
 rtl/laser_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_laser_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared constants, controller state encoding and coordinate helpers for the
// LASER coverage sequencer.
package laser_pkg;

  localparam int COORD_W = 4;
  localparam int CNT_W   = 6;
  localparam int GRID    = 16;
  localparam int NPTS    = 40;
  localparam int R2_MAX  = 16;
  localparam int IDX_W   = 2 * COORD_W;

  typedef enum logic [2:0] {
    IDLE,
    SCAN1,
    DRAIN1,
    SCAN2,
    DRAIN2,
    CHECK,
    FINISH
  } ctrl_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } coord_t;

  // Raster order with x fastest: low nibble of the index is x.
  function automatic coord_t raster_xy(input logic [IDX_W-1:0] k);
    coord_t c;
    c.x = k[COORD_W-1:0];
    c.y = k[IDX_W-1:COORD_W];
    return c;
  endfunction

endpackage

// File: rtl/laser_scan_ctrl_best_tracker.sv
// Pairs each returning coverage count with its own candidate (LAT-deep delay)
// and keeps the strictly-best candidate seen since the last incumbent load.
module laser_best_tracker
  import laser_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cand_vld,
  input  coord_t           cand_xy,
  input  logic [CNT_W-1:0] cnt,
  input  logic             load,
  input  logic [CNT_W-1:0] load_cnt,
  input  coord_t           load_xy,
  output logic [CNT_W-1:0] best_cnt_nxt,
  output coord_t           best_xy_nxt
);

  logic [LAT-1:0]   vld_p;
  coord_t           xy_p [LAT];
  logic [CNT_W-1:0] best_cnt;
  coord_t           best_xy;
  logic             take;

  // alignment stage: candidate issued LAT cycles ago sits in the last slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= cand_vld;
      for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    xy_p[0] <= cand_xy;
    for (int i = 1; i < LAT; i++) xy_p[i] <= xy_p[i-1];
  end

  // compare stage: strict greater keeps the earliest raster hit on ties
  assign take         = vld_p[LAT-1] && (cnt > best_cnt);
  assign best_cnt_nxt = take ? cnt : best_cnt;
  assign best_xy_nxt  = take ? xy_p[LAT-1] : best_xy;

  always_ff @(posedge clk) begin
    if (load) begin
      best_cnt <= load_cnt;
      best_xy  <= load_xy;
    end else begin
      best_cnt <= best_cnt_nxt;
      best_xy  <= best_xy_nxt;
    end
  end

endmodule

// File: rtl/laser_scan_ctrl.sv
// Coordinate-descent sequencer: sweeps all grid candidates for C1 then C2 each
// pass, commits the best, and stops when a pass stops improving coverage.
module laser_scan_ctrl
  import laser_pkg::*;
#(
  parameter int LAT        = 1,
  parameter int MAX_PASSES = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [CNT_W-1:0]   CNT,
  output logic [COORD_W-1:0] CAND_X,
  output logic [COORD_W-1:0] CAND_Y,
  output logic               CAND_VLD,
  output logic [COORD_W-1:0] FIX_X,
  output logic [COORD_W-1:0] FIX_Y,
  output logic               FIX_EN,
  output logic [COORD_W-1:0] C1X,
  output logic [COORD_W-1:0] C1Y,
  output logic [COORD_W-1:0] C2X,
  output logic [COORD_W-1:0] C2Y,
  output logic               BUSY,
  output logic               DONE
);

  localparam logic [2:0] DRAIN_LAST = 3'(LAT - 1);
  localparam logic [3:0] PASS_LAST  = 4'(MAX_PASSES - 1);

  ctrl_state_e      state;
  logic [IDX_W-1:0] idx;
  logic [2:0]       drain;
  logic [3:0]       pass;
  logic [CNT_W-1:0] cur_total;
  logic [CNT_W-1:0] start_total;
  coord_t           c1;
  coord_t           c2;
  coord_t           fix;
  coord_t           cand;
  logic             cand_vld;
  logic             fix_en;
  logic             busy;
  logic             done;

  logic             drain_last;
  logic             finish_now;
  logic             trk_load;
  logic [CNT_W-1:0] trk_load_cnt;
  coord_t           trk_load_xy;
  logic [CNT_W-1:0] best_cnt_nxt;
  coord_t           best_xy_nxt;

  assign cand       = raster_xy(idx);
  assign drain_last = (drain == DRAIN_LAST);
  assign finish_now = ((pass != 4'd0) && (cur_total == start_total)) ||
                      (pass == PASS_LAST);

  // Incumbent is reloaded on the same edge that enters each scan state.
  always_comb begin
    trk_load     = 1'b0;
    trk_load_cnt = cur_total;
    trk_load_xy  = c1;
    unique case (state)
      IDLE: begin
        trk_load     = START;
        trk_load_cnt = '0;
        trk_load_xy  = '0;
      end
      DRAIN1: begin
        trk_load     = drain_last;
        trk_load_cnt = best_cnt_nxt;
        trk_load_xy  = c2;
      end
      CHECK: begin
        trk_load = !finish_now;
      end
      default: begin
        trk_load = 1'b0;
      end
    endcase
  end

  laser_best_tracker #(
    .LAT (LAT)
  ) u_best (
    .clk          (CLK),
    .rst_n        (RST_N),
    .cand_vld     (cand_vld),
    .cand_xy      (cand),
    .cnt          (CNT),
    .load         (trk_load),
    .load_cnt     (trk_load_cnt),
    .load_xy      (trk_load_xy),
    .best_cnt_nxt (best_cnt_nxt),
    .best_xy_nxt  (best_xy_nxt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      idx         <= '0;
      drain       <= '0;
      pass        <= '0;
      cur_total   <= '0;
      start_total <= '0;
      c1          <= '0;
      c2          <= '0;
      fix         <= '0;
      cand_vld    <= 1'b0;
      fix_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            state       <= SCAN1;
            idx         <= '0;
            pass        <= '0;
            cur_total   <= '0;
            start_total <= '0;
            c1          <= '0;
            c2          <= '0;
            fix         <= '0;
            fix_en      <= 1'b0;
            cand_vld    <= 1'b1;
            busy        <= 1'b1;
          end
        end
        SCAN1, SCAN2: begin
          idx <= idx + 1'b1;
          if (idx == '1) begin
            state    <= (state == SCAN1) ? DRAIN1 : DRAIN2;
            cand_vld <= 1'b0;
            drain    <= '0;
          end
        end
        // The last drain cycle sees the final candidate's count, so the
        // commit takes the tracker's look-ahead value rather than its register.
        DRAIN1: begin
          if (drain_last) begin
            c1        <= best_xy_nxt;
            cur_total <= best_cnt_nxt;
            fix       <= best_xy_nxt;
            fix_en    <= 1'b1;
            cand_vld  <= 1'b1;
            drain     <= '0;
            state     <= SCAN2;
          end else begin
            drain <= drain + 3'd1;
          end
        end
        DRAIN2: begin
          if (drain_last) begin
            c2        <= best_xy_nxt;
            cur_total <= best_cnt_nxt;
            drain     <= '0;
            state     <= CHECK;
          end else begin
            drain <= drain + 3'd1;
          end
        end
        CHECK: begin
          if (finish_now) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state       <= SCAN1;
            pass        <= pass + 4'd1;
            start_total <= cur_total;
            fix         <= c2;
            fix_en      <= 1'b1;
            cand_vld    <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign CAND_X   = cand.x;
  assign CAND_Y   = cand.y;
  assign CAND_VLD = cand_vld;
  assign FIX_X    = fix.x;
  assign FIX_Y    = fix.y;
  assign FIX_EN   = fix_en;
  assign C1X      = c1.x;
  assign C1Y      = c1.y;
  assign C2X      = c2.x;
  assign C2Y      = c2.y;
  assign BUSY     = busy;
  assign DONE     = done;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Bench for laser_scan_ctrl: three instances (LAT=1/MAX=4, LAT=1/MAX=1,
// LAT=3/MAX=4) fed by a behavioural coverage evaluator over a shared point set.
module tb_laser_scan_ctrl;
  import laser_pkg::*;

  function automatic int lat_of(input int d);
    return (d == 2) ? 3 : 1;
  endfunction

  function automatic int mp_of(input int d);
    return (d == 1) ? 1 : 4;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [3];
  logic [5:0] cnt [3];
  logic [3:0] cand_x [3];
  logic [3:0] cand_y [3];
  logic [3:0] fix_x [3];
  logic [3:0] fix_y [3];
  logic [3:0] c1x [3];
  logic [3:0] c1y [3];
  logic [3:0] c2x [3];
  logic [3:0] c2y [3];
  logic       cand_vld [3];
  logic       fix_en [3];
  logic       busy [3];
  logic       done [3];

  int px [NPTS];
  int py [NPTS];
  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  function automatic int cover_cnt(input int cx, input int cy, input int fx,
                                   input int fy, input bit fen);
    int n, d1, d2;
    n = 0;
    for (int i = 0; i < NPTS; i++) begin
      d1 = (px[i] - cx) * (px[i] - cx) + (py[i] - cy) * (py[i] - cy);
      d2 = (px[i] - fx) * (px[i] - fx) + (py[i] - fy) * (py[i] - fy);
      if (d1 <= R2_MAX || (fen && d2 <= R2_MAX)) n++;
    end
    return n;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [5:0] dly [4];

    laser_scan_ctrl #(
      .LAT        (lat_of(g)),
      .MAX_PASSES (mp_of(g))
    ) u_dut (
      .CLK      (clk),
      .RST_N    (rst_n),
      .START    (start[g]),
      .CNT      (cnt[g]),
      .CAND_X   (cand_x[g]),
      .CAND_Y   (cand_y[g]),
      .CAND_VLD (cand_vld[g]),
      .FIX_X    (fix_x[g]),
      .FIX_Y    (fix_y[g]),
      .FIX_EN   (fix_en[g]),
      .C1X      (c1x[g]),
      .C1Y      (c1y[g]),
      .C2X      (c2x[g]),
      .C2Y      (c2y[g]),
      .BUSY     (busy[g]),
      .DONE     (done[g])
    );

    // Evaluator: invalid slots return junk so only aligned-valid counts matter.
    always @(posedge clk) begin
      if (cand_vld[g])
        dly[0] <= 6'(cover_cnt(cand_x[g], cand_y[g], fix_x[g], fix_y[g], fix_en[g]));
      else
        dly[0] <= 6'($urandom_range(0, NPTS));
      for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
    end

    assign cnt[g] = dly[lat_of(g) - 1];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [63:0] outs(input int d);
    return 64'({cand_x[d], cand_y[d], cand_vld[d], fix_x[d], fix_y[d], fix_en[d],
                c1x[d], c1y[d], c2x[d], c2y[d], busy[d], done[d]});
  endfunction

  // Reference: plain coordinate descent over the grid with strict improvement.
  task automatic model(input int maxp, output int m1x, output int m1y, output int m2x,
                       output int m2y, output int mtot, output int mpass);
    int bx, by, best, st, v;
    m1x = 0; m1y = 0; m2x = 0; m2y = 0; mtot = 0; mpass = 0;
    for (int p = 0; p < maxp; p++) begin
      st = mtot;
      best = mtot; bx = m1x; by = m1y;
      for (int k = 0; k < GRID * GRID; k++) begin
        v = cover_cnt(k % GRID, k / GRID, m2x, m2y, p > 0);
        if (v > best) begin best = v; bx = k % GRID; by = k / GRID; end
      end
      m1x = bx; m1y = by; mtot = best;
      best = mtot; bx = m2x; by = m2y;
      for (int k = 0; k < GRID * GRID; k++) begin
        v = cover_cnt(k % GRID, k / GRID, m1x, m1y, 1'b1);
        if (v > best) begin best = v; bx = k % GRID; by = k / GRID; end
      end
      m2x = bx; m2y = by; mtot = best;
      mpass = p + 1;
      if (p > 0 && mtot == st) break;
    end
  endtask

  task automatic set_all(input int x, input int y);
    for (int i = 0; i < NPTS; i++) begin px[i] = x; py[i] = y; end
  endtask

  task automatic set_two();
    for (int i = 0; i < NPTS; i++) begin
      px[i] = (i < 20) ? 2 : 12;
      py[i] = (i < 20) ? 2 : 12;
    end
  endtask

  task automatic set_rand();
    int cx [3];
    int cy [3];
    int v;
    for (int c = 0; c < 3; c++) begin
      cx[c] = $urandom_range(0, GRID - 1);
      cy[c] = $urandom_range(0, GRID - 1);
    end
    for (int i = 0; i < NPTS; i++) begin
      v = cx[i % 3] + $urandom_range(0, 8) - 4;
      px[i] = (v < 0) ? 0 : (v > GRID - 1) ? GRID - 1 : v;
      v = cy[i % 3] + $urandom_range(0, 8) - 4;
      py[i] = (v < 0) ? 0 : (v > GRID - 1) ? GRID - 1 : v;
    end
  endtask

  task automatic run_scn(input int d, input string name, input bit spam,
                         output int lat_cycles);
    int m1x, m1y, m2x, m2y, mtot, mpass, lat, n, exp_k, vld_hi;
    int raster_err, lowrun, run_a, run_b, run_bad;
    bit seen;
    model(mp_of(d), m1x, m1y, m2x, m2y, mtot, mpass);
    lat = lat_of(d);
    @(posedge clk); #1 start[d] = 1'b1;
    @(posedge clk); #1 start[d] = 1'b0;
    chk($sformatf("%s_busy_on", name), busy[d], 1);
    n = 0; seen = 0; exp_k = 0; vld_hi = 0; raster_err = 0;
    lowrun = 0; run_a = 0; run_b = 0; run_bad = 0;
    while (!seen && n < 20000) begin
      if (cand_vld[d]) begin
        if ({cand_y[d], cand_x[d]} != 8'(exp_k)) raster_err++;
        exp_k++; vld_hi++;
        if (lowrun == lat) run_a++;
        else if (lowrun == lat + 1) run_b++;
        else if (lowrun != 0) run_bad++;
        lowrun = 0;
      end else begin
        lowrun++;
      end
      if (spam) start[d] = (n % 37 == 5);
      @(posedge clk); #1;
      n++;
      if (done[d]) seen = 1;
    end
    start[d] = 1'b0;
    if (lowrun == lat + 1) run_b++;
    else if (lowrun != 0) run_bad++;
    lat_cycles = n;
    chk($sformatf("%s_latency", name), n, mpass * (2 * (256 + lat) + 1));
    chk($sformatf("%s_busy_at_done", name), busy[d], 1);
    chk($sformatf("%s_c1", name), {c1x[d], c1y[d]}, {4'(m1x), 4'(m1y)});
    chk($sformatf("%s_c2", name), {c2x[d], c2y[d]}, {4'(m2x), 4'(m2y)});
    chk($sformatf("%s_cover", name), cover_cnt(c1x[d], c1y[d], c2x[d], c2y[d], 1'b1), mtot);
    chk($sformatf("%s_vld_cycles", name), vld_hi, mpass * 512);
    chk($sformatf("%s_raster", name), raster_err, 0);
    chk($sformatf("%s_drain_runs", name), {16'(run_a), 16'(run_b), 16'(run_bad)},
        {16'(mpass), 16'(mpass), 16'd0});
    @(posedge clk); #1;
    chk($sformatf("%s_done_width", name), done[d], 0);
    chk($sformatf("%s_busy_off", name), busy[d], 0);
    chk($sformatf("%s_hold", name), {c1x[d], c1y[d], c2x[d], c2y[d]},
        {4'(m1x), 4'(m1y), 4'(m2x), 4'(m2y)});
  endtask

  initial begin
    int lc, dcount;
    for (int d = 0; d < 3; d++) start[d] = 1'b0;
    set_all(0, 0);
    #3;
    for (int d = 0; d < 3; d++) chk($sformatf("reset_outs%0d", d), outs(d), 0);
    @(negedge clk) rst_n = 1'b1;

    // single cluster at (5,7)
    set_all(5, 7);
    run_scn(0, "one", 1'b0, lc);
    chk("one_lat_const", lc, 1030);
    chk("one_c1_const", {c1x[0], c1y[0], c2x[0], c2y[0]}, {4'd5, 4'd3, 4'd0, 4'd0});

    // two clusters: (12,8) tie rejected for C1, taken for C2
    set_two();
    run_scn(0, "two", 1'b0, lc);
    chk("two_lat_const", lc, 1030);
    chk("two_c_const", {c1x[0], c1y[0], c2x[0], c2y[0]}, {4'd0, 4'd0, 4'd12, 4'd8});
    chk("two_cover_const", cover_cnt(c1x[0], c1y[0], c2x[0], c2y[0], 1'b1), 40);

    run_scn(0, "spam", 1'b1, lc);
    chk("spam_lat_const", lc, 1030);
    chk("spam_c_const", {c1x[0], c1y[0], c2x[0], c2y[0]}, {4'd0, 4'd0, 4'd12, 4'd8});

    run_scn(1, "mp1", 1'b0, lc);
    chk("mp1_lat_const", lc, 515);
    chk("mp1_c_const", {c1x[1], c1y[1], c2x[1], c2y[1]}, {4'd0, 4'd0, 4'd12, 4'd8});

    run_scn(2, "lat3", 1'b0, lc);
    chk("lat3_lat_const", lc, 2 * 519);
    chk("lat3_c_const", {c1x[2], c1y[2], c2x[2], c2y[2]}, {4'd0, 4'd0, 4'd12, 4'd8});

    // asynchronous reset in the middle of SCAN2
    set_rand();
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (300) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_outs", outs(0), 0);
    dcount = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done[0]) dcount++;
    end
    chk("arst_no_done", dcount, 0);
    @(negedge clk) rst_n = 1'b1;
    run_scn(0, "arst_rerun", 1'b0, lc);

    // randomized clustered point sets
    for (int r = 0; r < 3; r++) begin
      set_rand();
      run_scn(0, $sformatf("rnd%0d", r), 1'b0, lc);
    end
    set_rand();
    run_scn(1, "rnd_mp1", 1'b0, lc);
    set_rand();
    run_scn(2, "rnd_lat3", 1'b1, lc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
